// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs, EX/MEM and MEM/WB writeback info,
// and the registered/forwarded EX-side outputs of the ID/EX stage.
// The master modport is the environment (decode stage, later stages, ALU).
// The slave modport is the stage itself.
interface id_ex_stage_if;
    // decode side
    logic        id_valid;
    logic        id_ready;
    logic        flush;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [1:0]  id_aluop;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        id_alusrc;
    logic        id_memread;
    logic        id_memwrite;
    logic        id_regwrite;
    // writeback info from later stages
    logic [4:0]  exmem_rd;
    logic        exmem_regwrite;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_regwrite;
    logic [31:0] memwb_result;
    // EX side
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_regwrite;

    modport master (
        output id_valid, flush, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_aluop, id_funct3,
               id_funct7b5, id_alusrc, id_memread, id_memwrite, id_regwrite,
               exmem_rd, exmem_regwrite, exmem_result,
               memwb_rd, memwb_regwrite, memwb_result,
        input  id_ready, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data,
               ex_pc, ex_rd, ex_memread, ex_memwrite, ex_regwrite
    );

    modport slave (
        input  id_valid, flush, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_aluop, id_funct3,
               id_funct7b5, id_alusrc, id_memread, id_memwrite, id_regwrite,
               exmem_rd, exmem_regwrite, exmem_result,
               memwb_rd, memwb_regwrite, memwb_result,
        output id_ready, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data,
               ex_pc, ex_rd, ex_memread, ex_memwrite, ex_regwrite
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode,
// load-use / RAW hazard detection and operand forwarding.
// Build option FORWARDING_EN: when defined, EX/MEM and MEM/WB results are
// forwarded into the ALU operands and only load-use stalls. When undefined,
// operands come straight from the registered read data and any RAW against
// the EX or EX/MEM destination stalls decode instead.
module id_ex_stage (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    // registered EX state
    logic        ex_valid_reg;
    logic [31:0] ex_pc_reg;
    logic [4:0]  ex_rs1_reg;
    logic [4:0]  ex_rs2_reg;
    logic [4:0]  ex_rd_reg;
    logic [31:0] ex_rs1_data_reg;
    logic [31:0] ex_rs2_data_reg;
    logic [31:0] ex_imm_reg;
    logic        ex_alusrc_reg;
    logic [3:0]  alu_ctrl_reg;
    logic        ex_memread_reg;
    logic        ex_memwrite_reg;
    logic        ex_regwrite_reg;

    logic [3:0]  alu_ctrl_next;
    logic        hz;
    logic        load_en;

    // per-source views so both operands share one generate body
    logic [4:0]  id_rs      [2];
    logic [4:0]  ex_rs      [2];
    logic [31:0] ex_rs_data [2];
    logic [31:0] fwd_data   [2];

    assign id_rs[0]      = bus.id_rs1;
    assign id_rs[1]      = bus.id_rs2;
    assign ex_rs[0]      = ex_rs1_reg;
    assign ex_rs[1]      = ex_rs2_reg;
    assign ex_rs_data[0] = ex_rs1_data_reg;
    assign ex_rs_data[1] = ex_rs2_data_reg;

    // ALU control decode from aluop/funct3/funct7b5 (f7b5 only matters for R-type)
    always_comb begin
        alu_ctrl_next = 4'b0010;
        case (bus.id_aluop)
            2'b00:   alu_ctrl_next = 4'b0010;
            2'b01:   alu_ctrl_next = 4'b0100;
            default: begin
                case (bus.id_funct3)
                    3'b000:  alu_ctrl_next = (bus.id_aluop == 2'b10 && bus.id_funct7b5)
                                             ? 4'b0100 : 4'b0010;
                    3'b111:  alu_ctrl_next = 4'b0000;
                    3'b110:  alu_ctrl_next = 4'b0001;
                    3'b010:  alu_ctrl_next = 4'b1000;
                    default: alu_ctrl_next = 4'b0010;
                endcase
            end
        endcase
    end

`ifdef FORWARDING_EN
    // only a load in EX can't be covered by forwarding
    assign hz = bus.id_valid & ex_valid_reg & ex_memread_reg & (ex_rd_reg != 5'd0) &
                ((ex_rd_reg == bus.id_rs1) | (ex_rd_reg == bus.id_rs2));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // EX/MEM beats MEM/WB; x0 is never forwarded
            assign fwd_data[gi] =
                (bus.exmem_regwrite && bus.exmem_rd != 5'd0 && bus.exmem_rd == ex_rs[gi])
                    ? bus.exmem_result :
                (bus.memwb_regwrite && bus.memwb_rd != 5'd0 && bus.memwb_rd == ex_rs[gi])
                    ? bus.memwb_result : ex_rs_data[gi];
        end
    endgenerate
`else
    logic [1:0] src_raw;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_raw
            // any pending write to this source in EX or EX/MEM forces a stall
            assign src_raw[gi] = (id_rs[gi] != 5'd0) &
                ((ex_valid_reg & ex_regwrite_reg & (ex_rd_reg == id_rs[gi])) |
                 (bus.exmem_regwrite & (bus.exmem_rd == id_rs[gi])));
            // no forwarding path: register file write-through covers MEM/WB
            assign fwd_data[gi] = ex_rs_data[gi];
        end
    endgenerate

    assign hz = bus.id_valid & (|src_raw);

    // source indices and late results are only needed by the forwarding muxes
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs[0], ex_rs[1], bus.exmem_result,
                                 bus.memwb_rd, bus.memwb_regwrite, bus.memwb_result};
`endif

    assign load_en     = bus.id_valid & ~bus.flush & ~hz;
    assign bus.id_ready = ~hz | bus.flush;

    // ID/EX register: load the decoded instruction, otherwise insert a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_reg    <= 1'b0;
            ex_pc_reg       <= '0;
            ex_rs1_reg      <= '0;
            ex_rs2_reg      <= '0;
            ex_rd_reg       <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_alusrc_reg   <= 1'b0;
            alu_ctrl_reg    <= '0;
            ex_memread_reg  <= 1'b0;
            ex_memwrite_reg <= 1'b0;
            ex_regwrite_reg <= 1'b0;
        end else if (load_en) begin
            ex_valid_reg    <= 1'b1;
            ex_pc_reg       <= bus.id_pc;
            ex_rs1_reg      <= bus.id_rs1;
            ex_rs2_reg      <= bus.id_rs2;
            ex_rd_reg       <= bus.id_rd;
            ex_rs1_data_reg <= bus.id_rs1_data;
            ex_rs2_data_reg <= bus.id_rs2_data;
            ex_imm_reg      <= bus.id_imm;
            ex_alusrc_reg   <= bus.id_alusrc;
            alu_ctrl_reg    <= alu_ctrl_next;
            ex_memread_reg  <= bus.id_memread;
            ex_memwrite_reg <= bus.id_memwrite;
            ex_regwrite_reg <= bus.id_regwrite;
        end else begin
            ex_valid_reg    <= 1'b0;
            ex_pc_reg       <= '0;
            ex_rs1_reg      <= '0;
            ex_rs2_reg      <= '0;
            ex_rd_reg       <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_alusrc_reg   <= 1'b0;
            alu_ctrl_reg    <= '0;
            ex_memread_reg  <= 1'b0;
            ex_memwrite_reg <= 1'b0;
            ex_regwrite_reg <= 1'b0;
        end
    end

    assign bus.ex_valid      = ex_valid_reg;
    assign bus.alu_a         = fwd_data[0];
    assign bus.alu_b         = ex_alusrc_reg ? ex_imm_reg : fwd_data[1];
    assign bus.ex_store_data = fwd_data[1];
    assign bus.alu_ctrl      = alu_ctrl_reg;
    assign bus.ex_pc         = ex_pc_reg;
    assign bus.ex_rd         = ex_rd_reg;
    assign bus.ex_memread    = ex_memread_reg;
    assign bus.ex_memwrite   = ex_memwrite_reg;
    assign bus.ex_regwrite   = ex_regwrite_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test-plan sequences followed by random traffic.
// The driver pushes the expected EX contents for every clock edge into a
// scoreboard queue; the monitor pops one entry per cycle and compares all
// EX outputs against a behavioural model of the stage.
module tb_id_ex_stage;

    typedef struct {
        logic        valid, flush;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7, alusrc, mr, mw, rw;
        logic [4:0]  em_rd;
        logic        em_rw;
        logic [31:0] em_res;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [31:0] wb_res;
    } stim_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        alusrc;
        logic [3:0]  ctrl;
        logic        mr, mw, rw;
    } ex_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    last_stalled = 1'b0;
    int    pc_ctr = 32'h100;
    ex_t   sb_q[$];
    ex_t   model_ex;
    stim_t cur_s;

    // ---------------- reference model ----------------
    function automatic ex_t bubble();
        ex_t b = '{default: '0};
        return b;
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: '0};
        return s;
    endfunction

    // ALU code table: loads/stores add, branches subtract, otherwise by funct3
    function automatic logic [3:0] model_ctrl(logic [1:0] aluop, logic [2:0] f3, logic f7);
        if (aluop == 2'd0) return 4'b0010;
        if (aluop == 2'd1) return 4'b0100;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        if (f3 == 3'b010) return 4'b1000;
        if (f3 == 3'b000 && aluop == 2'd2 && f7) return 4'b0100;
        return 4'b0010;
    endfunction

    function automatic logic model_hz(ex_t e, stim_t s);
        logic [4:0] r;
        if (!s.valid) return 1'b0;
`ifdef FORWARDING_EN
        r = e.rd;
        return e.v && e.mr && (r != 0) && (r == s.rs1 || r == s.rs2);
`else
        for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? s.rs1 : s.rs2;
            if (r != 0 && ((e.v && e.rw && e.rd == r) || (s.em_rw && s.em_rd == r)))
                return 1'b1;
        end
        return 1'b0;
`endif
    endfunction

    function automatic ex_t model_next(ex_t e, stim_t s);
        ex_t n = bubble();
        if (s.flush || model_hz(e, s) || !s.valid) return n;
        n.v = 1'b1;   n.pc = s.pc;   n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd;
        n.d1 = s.d1;  n.d2 = s.d2;   n.imm = s.imm; n.alusrc = s.alusrc;
        n.ctrl = model_ctrl(s.aluop, s.f3, s.f7);
        n.mr = s.mr;  n.mw = s.mw;   n.rw = s.rw;
        return n;
    endfunction

    // value an EX source sees given the later stages' writeback this cycle
    function automatic logic [31:0] model_fwd(logic [4:0] rs, logic [31:0] data, stim_t s);
`ifdef FORWARDING_EN
        if (rs != 0) begin
            if (s.em_rw && s.em_rd == rs) return s.em_res;
            if (s.wb_rw && s.wb_rd == rs) return s.wb_res;
        end
`endif
        return data;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(stim_t s);
        bus.id_valid       = s.valid;
        bus.flush          = s.flush;
        bus.id_pc          = s.pc;
        bus.id_rs1         = s.rs1;
        bus.id_rs2         = s.rs2;
        bus.id_rd          = s.rd;
        bus.id_rs1_data    = s.d1;
        bus.id_rs2_data    = s.d2;
        bus.id_imm         = s.imm;
        bus.id_aluop       = s.aluop;
        bus.id_funct3      = s.f3;
        bus.id_funct7b5    = s.f7;
        bus.id_alusrc      = s.alusrc;
        bus.id_memread     = s.mr;
        bus.id_memwrite    = s.mw;
        bus.id_regwrite    = s.rw;
        bus.exmem_rd       = s.em_rd;
        bus.exmem_regwrite = s.em_rw;
        bus.exmem_result   = s.em_res;
        bus.memwb_rd       = s.wb_rd;
        bus.memwb_regwrite = s.wb_rw;
        bus.memwb_result   = s.wb_res;
    endtask

    task automatic drive_and_push(stim_t s);
        ex_t n;
        cur_s = s;
        apply(s);
        last_stalled = model_hz(model_ex, s) && !s.flush;
        n = model_next(model_ex, s);
        sb_q.push_back(n);
        model_ex = n;
    endtask

    task automatic step(stim_t s);
        @(posedge clk);
        #1;
        drive_and_push(s);
    endtask

    // deassert reset and restart the scoreboard from an empty EX stage
    task automatic release_reset(stim_t s);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        model_ex = bubble();
        sb_q.push_back(model_ex);
        mon_en = 1'b1;
        drive_and_push(s);
    endtask

    function automatic stim_t mk(logic [1:0] aluop, logic [2:0] f3, logic f7,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                 logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                                 logic alusrc, logic mr, logic mw, logic rw);
        stim_t s = idle();
        s.valid = 1'b1; s.pc = pc_ctr;
        s.aluop = aluop; s.f3 = f3; s.f7 = f7;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.d1 = d1; s.d2 = d2; s.imm = imm;
        s.alusrc = alusrc; s.mr = mr; s.mw = mw; s.rw = rw;
        pc_ctr = pc_ctr + 4;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ex_t e;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got=0 exp=1 t=%0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("id_ready",      {31'd0, bus.id_ready},    {31'd0, ~model_hz(e, cur_s) | cur_s.flush});
                chk("ex_valid",      {31'd0, bus.ex_valid},    {31'd0, e.v});
                chk("ex_pc",         bus.ex_pc,                e.pc);
                chk("ex_rd",         {27'd0, bus.ex_rd},       {27'd0, e.rd});
                chk("ex_memread",    {31'd0, bus.ex_memread},  {31'd0, e.mr});
                chk("ex_memwrite",   {31'd0, bus.ex_memwrite}, {31'd0, e.mw});
                chk("ex_regwrite",   {31'd0, bus.ex_regwrite}, {31'd0, e.rw});
                chk("alu_ctrl",      {28'd0, bus.alu_ctrl},    {28'd0, e.ctrl});
                chk("alu_a",         bus.alu_a,                model_fwd(e.rs1, e.d1, cur_s));
                chk("alu_b",         bus.alu_b,
                    e.alusrc ? e.imm : model_fwd(e.rs2, e.d2, cur_s));
                chk("ex_store_data", bus.ex_store_data,        model_fwd(e.rs2, e.d2, cur_s));
                if (bus.ex_valid)
                    $display("EX pc=%h rd=%0d ctrl=%b a=%h b=%h st=%h rdy=%b",
                             bus.ex_pc, bus.ex_rd, bus.alu_ctrl, bus.alu_a, bus.alu_b,
                             bus.ex_store_data, bus.id_ready);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s, user, lw;
        reset = 1'b1;
        model_ex = bubble();
        cur_s = idle();
        apply(idle());
        repeat (2) @(posedge clk);
        release_reset(idle());

        // ADD x3,x1,x2 with 5/7, no later-stage writes
        step(mk(2'b10, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        // SUB x6,x1,x2 then EX/MEM and MEM/WB both target x1
        step(mk(2'b10, 3'b000, 1'b1, 5'd1, 5'd2, 5'd6, 32'h111, 32'h222, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        s = idle();
        s.em_rd = 5'd1; s.em_rw = 1'b1; s.em_res = 32'h10;
        s.wb_rd = 5'd1; s.wb_rw = 1'b1; s.wb_res = 32'h20;
        step(s);
        // same SUB, later stages write x0: no forwarding
        step(mk(2'b10, 3'b000, 1'b1, 5'd1, 5'd2, 5'd6, 32'h111, 32'h222, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        s.em_rd = 5'd0; s.wb_rd = 5'd0;
        step(s);

        // LW x5 then a user of x5: one stall cycle, then it proceeds
        lw   = mk(2'b00, 3'b010, 1'b0, 5'd2, 5'd0, 5'd5, 32'h40, 32'd0, 32'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        user = mk(2'b10, 3'b000, 1'b0, 5'd5, 5'd1, 5'd7, 32'h55, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(lw);
        step(user);
        step(user);
        step(idle());

        // flush during a load-use hazard
        step(lw);
        user.flush = 1'b1;
        step(user);
        user.flush = 1'b0;
        step(idle());

        // ADD x4 then a user of x4, with x4 then sitting in EX/MEM
        step(mk(2'b10, 3'b000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        user = mk(2'b10, 3'b111, 1'b0, 5'd4, 5'd2, 5'd8, 32'h0f0, 32'h0ff, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(user);
        user.em_rd = 5'd4; user.em_rw = 1'b1; user.em_res = 32'd7;
        step(user);
        user.em_rd = 5'd0; user.em_rw = 1'b0;
        step(user);
        step(idle());

        // SLTI x9,x1,3 (f7b5 set but ignored for I-type)
        step(mk(2'b11, 3'b010, 1'b1, 5'd1, 5'd3, 5'd9, 32'd2, 32'd99, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1));
        step(idle());

        // reset asserted in the middle of a load-use stall
        step(lw);
        user = mk(2'b10, 3'b110, 1'b0, 5'd5, 5'd5, 5'd10, 32'h1, 32'h2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(user);
        #2;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_ex_valid",    {31'd0, bus.ex_valid},    32'd0);
        chk("rst_id_ready",    {31'd0, bus.id_ready},    32'd1);
        chk("rst_alu_ctrl",    {28'd0, bus.alu_ctrl},    32'd0);
        chk("rst_alu_a",       bus.alu_a,                32'd0);
        chk("rst_alu_b",       bus.alu_b,                32'd0);
        chk("rst_store_data",  bus.ex_store_data,        32'd0);
        chk("rst_ex_pc",       bus.ex_pc,                32'd0);
        chk("rst_ex_rd",       {27'd0, bus.ex_rd},       32'd0);
        chk("rst_ex_regwrite", {31'd0, bus.ex_regwrite}, 32'd0);
        chk("rst_ex_memread",  {31'd0, bus.ex_memread},  32'd0);
        release_reset(idle());

        // random traffic; decode holds its instruction while stalled
        s = idle();
        for (int i = 0; i < 400; i++) begin
            if (!last_stalled) begin
                s.valid  = ($urandom_range(0, 3) != 0);
                s.pc     = $urandom;
                s.rs1    = 5'($urandom_range(0, 3));
                s.rs2    = 5'($urandom_range(0, 3));
                s.rd     = 5'($urandom_range(0, 3));
                s.d1     = $urandom;
                s.d2     = $urandom;
                s.imm    = $urandom;
                s.aluop  = 2'($urandom_range(0, 3));
                s.f3     = 3'($urandom_range(0, 7));
                s.f7     = 1'($urandom_range(0, 1));
                s.alusrc = 1'($urandom_range(0, 1));
                s.mr     = ($urandom_range(0, 2) == 0);
                s.mw     = 1'($urandom_range(0, 1));
                s.rw     = 1'($urandom_range(0, 1));
            end
            s.flush  = ($urandom_range(0, 9) == 0);
            s.em_rd  = 5'($urandom_range(0, 3));
            s.em_rw  = ($urandom_range(0, 2) == 0);
            s.em_res = $urandom;
            s.wb_rd  = 5'($urandom_range(0, 3));
            s.wb_rw  = 1'($urandom_range(0, 1));
            s.wb_res = $urandom;
            step(s);
        end
        step(idle());
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
